// File: rtl/ace_snapshot_loader_if.sv
// ace_snapshot_loader_if: hps_io download stream, CPU RAM port, arbitrated
// RAM port and core control lines of the Jupiter Ace snapshot loader.
// Defining ACE_LOADER_CHECKSUM_EN adds the load_sum signal.
interface ace_snapshot_loader_if;
    logic        ioctl_download;
    logic [7:0]  ioctl_index;
    logic        ioctl_wr;
    logic [7:0]  ioctl_dout;
    logic        ioctl_wait;
    logic [15:0] cpu_addr;
    logic [7:0]  cpu_dout;
    logic        cpu_we;
    logic [15:0] ram_addr;
    logic [7:0]  ram_din;
    logic        ram_we;
    logic        cpu_reset;
    logic        cpu_hold;
    logic        load_busy;
    logic        load_err;
`ifdef ACE_LOADER_CHECKSUM_EN
    logic [7:0]  load_sum;

    modport master (
        output ioctl_download, ioctl_index, ioctl_wr, ioctl_dout,
        output cpu_addr, cpu_dout, cpu_we,
        input  ioctl_wait, ram_addr, ram_din, ram_we,
        input  cpu_reset, cpu_hold, load_busy, load_err, load_sum
    );
    modport slave (
        input  ioctl_download, ioctl_index, ioctl_wr, ioctl_dout,
        input  cpu_addr, cpu_dout, cpu_we,
        output ioctl_wait, ram_addr, ram_din, ram_we,
        output cpu_reset, cpu_hold, load_busy, load_err, load_sum
    );
`else
    modport master (
        output ioctl_download, ioctl_index, ioctl_wr, ioctl_dout,
        output cpu_addr, cpu_dout, cpu_we,
        input  ioctl_wait, ram_addr, ram_din, ram_we,
        input  cpu_reset, cpu_hold, load_busy, load_err
    );
    modport slave (
        input  ioctl_download, ioctl_index, ioctl_wr, ioctl_dout,
        input  cpu_addr, cpu_dout, cpu_we,
        output ioctl_wait, ram_addr, ram_din, ram_we,
        output cpu_reset, cpu_hold, load_busy, load_err
    );
`endif
endinterface

// File: rtl/ace_snapshot_loader.sv
// ace_snapshot_loader: streams a .ACE snapshot from hps_io into main RAM,
// expanding ESC/count/value runs, and owns the RAM write port while loading.
// Optional: define ACE_LOADER_CHECKSUM_EN for the load_sum byte checksum.
module ace_snapshot_loader #(
    parameter logic [15:0] BASE_ADDR   = 16'h2000,
    parameter logic [7:0]  ESC_BYTE    = 8'hED,
    parameter int          HOLD_CYCLES = 3000000
) (
    input logic                  clk_sys,
    input logic                  reset_n,
    ace_snapshot_loader_if.slave bus
);
    localparam int          TW        = $clog2(HOLD_CYCLES + 1);
    localparam logic [TW-1:0] HOLD_LOAD = TW'(HOLD_CYCLES);

    typedef enum logic [2:0] {IDLE, START, LIT, CNT, VAL, FILL, HOLD} state_t;

    state_t        state_q, state_d;
    logic          dl_q;
    logic [15:0]   addr_q, ld_addr_q;
    logic [7:0]    ld_din_q, cnt_q, val_q, wr_byte;
    logic          ld_we_q, err_q;
    logic [TW-1:0] timer_q;
    logic          dl_rise, wr_lit, wr_fill, ld_cnt, ld_val, set_err, enter_hold, wait_c;
    logic          busy;
`ifdef ACE_LOADER_CHECKSUM_EN
    logic [7:0]    sum_q;
`endif

    assign dl_rise = bus.ioctl_download & ~dl_q;
    assign wr_byte = wr_fill ? val_q : bus.ioctl_dout;
    assign busy    = (state_q != IDLE);

    // Previous ioctl_download level for rising-edge detection
    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) dl_q <= 1'b0;
        else          dl_q <= bus.ioctl_download;
    end

    // State register
    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) state_q <= IDLE;
        else          state_q <= state_d;
    end

    // Next state and per-cycle strobes; a dropped download aborts any byte phase,
    // but a run already in FILL is always finished first.
    always_comb begin
        state_d    = state_q;
        wr_lit     = 1'b0;
        wr_fill    = 1'b0;
        ld_cnt     = 1'b0;
        ld_val     = 1'b0;
        set_err    = 1'b0;
        enter_hold = 1'b0;
        wait_c     = 1'b0;
        case (state_q)
            IDLE:  if (dl_rise && bus.ioctl_index != 8'd0) state_d = START;
            START: state_d = LIT;
            LIT: begin
                if (!bus.ioctl_download) begin
                    set_err = 1'b1;
                    state_d = HOLD;
                end else if (bus.ioctl_wr) begin
                    if (bus.ioctl_dout == ESC_BYTE) state_d = CNT;
                    else                            wr_lit  = 1'b1;
                end
            end
            CNT: begin
                if (!bus.ioctl_download) begin
                    set_err = 1'b1;
                    state_d = HOLD;
                end else if (bus.ioctl_wr) begin
                    ld_cnt  = 1'b1;
                    state_d = (bus.ioctl_dout == 8'd0) ? HOLD : VAL;
                end
            end
            VAL: begin
                if (!bus.ioctl_download) begin
                    set_err = 1'b1;
                    state_d = HOLD;
                end else if (bus.ioctl_wr) begin
                    ld_val  = 1'b1;
                    state_d = FILL;
                end
            end
            FILL: begin
                wr_fill = 1'b1;
                if (cnt_q == 8'd1) begin
                    if (!bus.ioctl_download) begin
                        set_err = 1'b1;
                        state_d = HOLD;
                    end else begin
                        state_d = LIT;
                    end
                end
            end
            HOLD:    if (timer_q == '0 && !bus.ioctl_download) state_d = IDLE;
            default: state_d = IDLE;
        endcase
        enter_hold = (state_d == HOLD) && (state_q != HOLD);
        // Stall is raised combinationally with the value byte so hps_io
        // never presents another byte during the expansion.
        wait_c     = ld_val || (state_q == FILL);
    end

    // Loader write port, address pointer and sticky error
    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            addr_q    <= BASE_ADDR;
            ld_addr_q <= '0;
            ld_din_q  <= '0;
            ld_we_q   <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            ld_we_q <= wr_lit | wr_fill;
            if (state_q == START) begin
                addr_q <= BASE_ADDR;
                err_q  <= 1'b0;
            end
            if (wr_lit || wr_fill) begin
                ld_addr_q <= addr_q;
                ld_din_q  <= wr_byte;
                addr_q    <= addr_q + 16'd1;
                if (addr_q == 16'hFFFF) err_q <= 1'b1;
            end
            if (set_err) err_q <= 1'b1;
        end
    end

    // Run count, run value and post-load hold timer
    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            cnt_q   <= '0;
            val_q   <= '0;
            timer_q <= '0;
        end else begin
            if (ld_cnt)       cnt_q <= bus.ioctl_dout;
            else if (wr_fill) cnt_q <= cnt_q - 8'd1;
            if (ld_val)       val_q <= bus.ioctl_dout;
            if (enter_hold)                          timer_q <= HOLD_LOAD;
            else if (state_q == HOLD && timer_q != '0) timer_q <= timer_q - 1'b1;
        end
    end

`ifdef ACE_LOADER_CHECKSUM_EN
    // Modulo-256 sum of every byte the loader writes
    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n)                 sum_q <= '0;
        else if (state_q == START)    sum_q <= '0;
        else if (wr_lit || wr_fill)   sum_q <= sum_q + wr_byte;
    end
    assign bus.load_sum = sum_q;
`endif

    assign bus.ram_addr   = busy ? ld_addr_q : bus.cpu_addr;
    assign bus.ram_din    = busy ? ld_din_q  : bus.cpu_dout;
    assign bus.ram_we     = busy ? ld_we_q   : bus.cpu_we;
    assign bus.ioctl_wait = wait_c;
    assign bus.cpu_reset  = (state_q == START);
    assign bus.cpu_hold   = busy;
    assign bus.load_busy  = busy;
    assign bus.load_err   = err_q;
endmodule

// File: tb/tb_ace_snapshot_loader.sv
// tb_ace_snapshot_loader: two loaders (base 2000 and FFFE) share one download
// stream; a format-level decoder predicts the written byte stream.
module tb_ace_snapshot_loader;
    localparam int          H      = 20;
    localparam logic [15:0] BASE_A = 16'h2000;
    localparam logic [15:0] BASE_B = 16'hFFFE;
    localparam logic [7:0]  ESC    = 8'hED;

    logic clk_sys = 1'b0;
    logic reset_n = 1'b0;
    always #5 clk_sys = ~clk_sys;

    ace_snapshot_loader_if ifa();
    ace_snapshot_loader_if ifb();
    assign ifb.ioctl_download = ifa.ioctl_download;
    assign ifb.ioctl_index    = ifa.ioctl_index;
    assign ifb.ioctl_wr       = ifa.ioctl_wr;
    assign ifb.ioctl_dout     = ifa.ioctl_dout;
    assign ifb.cpu_addr       = ifa.cpu_addr;
    assign ifb.cpu_dout       = ifa.cpu_dout;
    assign ifb.cpu_we         = ifa.cpu_we;

    ace_snapshot_loader #(.BASE_ADDR(BASE_A), .ESC_BYTE(ESC), .HOLD_CYCLES(H)) u_dut (
        .clk_sys(clk_sys), .reset_n(reset_n), .bus(ifa));
    ace_snapshot_loader #(.BASE_ADDR(BASE_B), .ESC_BYTE(ESC), .HOLD_CYCLES(H)) u_wrap (
        .clk_sys(clk_sys), .reset_n(reset_n), .bus(ifb));

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic fail_now(input string name);
        n_cmp++;
        n_bad++;
        $display("FAIL %s", name);
    endtask

    // Reference: expected writes, shadow RAM as observed, per-load counters
    logic [23:0] exp_a[$];
    logic [23:0] exp_b[$];
    logic [7:0]  sha_a [0:65535];
    logic [7:0]  sha_b [0:65535];
    int n_rst, n_wait, n_wr_a, n_wr_b, last_hold;

    // Format-level decode of the stimulus in g
    logic [7:0] g[$];
    logic [7:0] m_dec[$];
    int         m_kind[$];   // 0 literal, 1 escape/other, 3 run value byte
    int         m_wait;
    bit         m_end;

    function automatic void model();
        int i = 0;
        m_dec.delete(); m_kind.delete(); m_wait = 0; m_end = 1'b0;
        while (i < g.size()) begin
            if (g[i] != ESC) begin
                m_dec.push_back(g[i]); m_kind.push_back(0); i++;
            end else if (i + 1 < g.size() && g[i+1] == 8'd0) begin
                m_kind.push_back(1); m_kind.push_back(1); m_end = 1'b1;
                break;
            end else if (i + 2 < g.size()) begin
                for (int k = 0; k < int'(g[i+1]); k++) m_dec.push_back(g[i+2]);
                m_wait += int'(g[i+1]) + 1;
                m_kind.push_back(1); m_kind.push_back(1); m_kind.push_back(3);
                i += 3;
            end else begin
                while (i < g.size()) begin m_kind.push_back(1); i++; end
            end
        end
    endfunction

    // Every-cycle check: loader writes match the model; CPU passes through when idle
    always @(negedge clk_sys) begin
        if (ifa.ioctl_wait) n_wait++;
        if (ifa.cpu_reset)  n_rst++;
        if (ifa.load_busy) begin
            if (ifa.ram_we) begin
                n_wr_a++;
                sha_a[ifa.ram_addr] = ifa.ram_din;
                if (exp_a.size() == 0) fail_now("a_unexpected_write");
                else chk("a_write", {8'h0, ifa.ram_addr, ifa.ram_din}, {8'h0, exp_a.pop_front()});
            end
        end else begin
            chk("a_passthru", {7'h0, ifa.ram_addr, ifa.ram_din, ifa.ram_we},
                {7'h0, ifa.cpu_addr, ifa.cpu_dout, ifa.cpu_we});
            chk("a_idle_wait", ifa.ioctl_wait, 0);
        end
        if (ifb.load_busy) begin
            if (ifb.ram_we) begin
                n_wr_b++;
                sha_b[ifb.ram_addr] = ifb.ram_din;
                if (exp_b.size() == 0) fail_now("b_unexpected_write");
                else chk("b_write", {8'h0, ifb.ram_addr, ifb.ram_din}, {8'h0, exp_b.pop_front()});
            end
        end else begin
            chk("b_passthru", {7'h0, ifb.ram_addr, ifb.ram_din, ifb.ram_we},
                {7'h0, ifb.cpu_addr, ifb.cpu_dout, ifb.cpu_we});
        end
    end

    task automatic tick();
        @(posedge clk_sys); #1;
    endtask

    // Drive one full download of g and check its end-of-load outcome
    task automatic run_load(input bit inject);
        int guard;
        logic [7:0] sum;
        model();
        sum = 8'h00;
        for (int k = 0; k < m_dec.size(); k++) begin
            exp_a.push_back({BASE_A + 16'(k), m_dec[k]});
            exp_b.push_back({BASE_B + 16'(k), m_dec[k]});
            sum += m_dec[k];
        end
        n_rst = 0; n_wait = 0; n_wr_a = 0; n_wr_b = 0;
        ifa.ioctl_index    = 8'($urandom_range(1, 255));
        ifa.ioctl_download = 1'b1;
        tick();
        chk("start_cpu_reset", ifa.cpu_reset, 1);
        chk("start_cpu_hold", ifa.cpu_hold, 1);
        tick();
        for (int k = 0; k < g.size(); k++) begin
            repeat ($urandom_range(0, 2)) tick();
            ifa.cpu_addr = 16'($urandom);
            ifa.cpu_dout = 8'($urandom);
            ifa.cpu_we   = 1'($urandom_range(0, 1));
            guard = 0;
            while (ifa.ioctl_wait && guard < 300) begin tick(); guard++; end
            if (guard >= 300) fail_now("wait_timeout");
            ifa.ioctl_dout = g[k];
            ifa.ioctl_wr   = 1'b1;
            tick();
            ifa.ioctl_wr   = 1'b0;
            if (m_kind[k] == 0) begin
                chk("lit_latency_we", ifa.ram_we, 1);
                chk("lit_latency_din", ifa.ram_din, g[k]);
                chk("load_cpu_hold", ifa.cpu_hold, 1);
            end
            if (m_kind[k] == 3 && inject) begin
                chk("inject_wait_high", ifa.ioctl_wait, 1);
                ifa.ioctl_dout = 8'h77;
                ifa.ioctl_wr   = 1'b1;
                tick();
                ifa.ioctl_wr   = 1'b0;
            end
        end
        ifa.cpu_we         = 1'b0;
        ifa.ioctl_download = 1'b0;
        guard = 0;
        if (m_end) begin
            forever begin
                @(negedge clk_sys);
                if (!ifa.load_busy || guard > H + 50) break;
                guard++;
            end
            last_hold = guard;
            chk("hold_len", guard, H + 1);
        end else begin
            while (ifa.load_busy && guard < H + 300) begin @(negedge clk_sys); guard++; end
            if (ifa.load_busy) fail_now("abort_idle_timeout");
        end
        tick();
        chk("a_all_written", exp_a.size(), 0);
        chk("b_all_written", exp_b.size(), 0);
        chk("a_load_err", ifa.load_err, !m_end);
        chk("b_load_err", ifb.load_err, !m_end || (int'(BASE_B) + m_dec.size() >= 65536));
        chk("reset_pulses", n_rst, 1);
        chk("wait_cycles", n_wait, m_wait);
`ifdef ACE_LOADER_CHECKSUM_EN
        chk("a_load_sum", ifa.load_sum, sum);
        chk("b_load_sum", ifb.load_sum, sum);
`endif
        exp_a.delete();
        exp_b.delete();
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int n;
        ifa.ioctl_download = 1'b0; ifa.ioctl_index = 8'h00; ifa.ioctl_wr = 1'b0;
        ifa.ioctl_dout = 8'h00; ifa.cpu_addr = 16'h0000; ifa.cpu_dout = 8'h00; ifa.cpu_we = 1'b0;
        n_rst = 0; n_wait = 0; n_wr_a = 0; n_wr_b = 0; last_hold = 0;

        // Reset state
        repeat (3) @(posedge clk_sys);
        #1;
        chk("rst_busy", ifa.load_busy, 0);
        chk("rst_hold", ifa.cpu_hold, 0);
        chk("rst_cpu_reset", ifa.cpu_reset, 0);
        chk("rst_wait", ifa.ioctl_wait, 0);
        chk("rst_err", ifa.load_err, 0);
        chk("rst_ram_we", ifa.ram_we, 0);
`ifdef ACE_LOADER_CHECKSUM_EN
        chk("rst_sum", ifa.load_sum, 0);
`endif
        reset_n = 1'b1;
        tick();

        // Literal load
        g.delete(); g.push_back(8'h11); g.push_back(8'h22); g.push_back(8'h33);
        g.push_back(ESC); g.push_back(8'h00);
        run_load(1'b0);
        chk("lit_ram2000", sha_a[16'h2000], 8'h11);
        chk("lit_ram2001", sha_a[16'h2001], 8'h22);
        chk("lit_ram2002", sha_a[16'h2002], 8'h33);
        chk("lit_hold_cycles", last_hold, 21);
        chk("lit_nwr", n_wr_a, 3);

        // Run expansion with an ignored byte strobe during the stall
        g.delete(); g.push_back(ESC); g.push_back(8'h05); g.push_back(8'hAA);
        g.push_back(8'h44); g.push_back(ESC); g.push_back(8'h00);
        run_load(1'b1);
        for (int a = 0; a < 5; a++) chk("run_ramAA", sha_a[16'h2000 + 16'(a)], 8'hAA);
        chk("run_ram2005", sha_a[16'h2005], 8'h44);
        chk("run_nwr", n_wr_a, 6);
        chk("run_wait6", n_wait, 6);
`ifdef ACE_LOADER_CHECKSUM_EN
        chk("run_sum96", ifa.load_sum, 8'h96);
`endif

        // Wrap on the FFFE-based instance
        g.delete(); g.push_back(8'h01); g.push_back(8'h02); g.push_back(8'h03);
        g.push_back(ESC); g.push_back(8'h00);
        run_load(1'b0);
        chk("wrap_fffe", sha_b[16'hFFFE], 8'h01);
        chk("wrap_ffff", sha_b[16'hFFFF], 8'h02);
        chk("wrap_0000", sha_b[16'h0000], 8'h03);
        chk("wrap_err", ifb.load_err, 1);
        chk("nowrap_err", ifa.load_err, 0);

        // Index 0 download: ignored, CPU passes through with zero latency
        ifa.ioctl_index = 8'h00; ifa.ioctl_download = 1'b1;
        ifa.cpu_addr = 16'h3C00; ifa.cpu_dout = 8'h5A; ifa.cpu_we = 1'b1;
        #1;
        chk("idx0_addr", ifa.ram_addr, 16'h3C00);
        chk("idx0_din", ifa.ram_din, 8'h5A);
        chk("idx0_we", ifa.ram_we, 1);
        repeat (4) begin tick(); chk("idx0_busy", ifa.load_busy, 0); end
        ifa.ioctl_download = 1'b0; ifa.cpu_we = 1'b0;
        tick();

        // Download ends after ED 03
        g.delete(); g.push_back(ESC); g.push_back(8'h03);
        run_load(1'b0);
        chk("trunc_nwr", n_wr_a, 0);
        chk("trunc_err", ifa.load_err, 1);

        // Download ends while a run is expanding: run completes first
        g.delete(); g.push_back(ESC); g.push_back(8'h04); g.push_back(8'h55);
        run_load(1'b0);
        chk("fillabort_nwr", n_wr_a, 4);
        chk("fillabort_err", ifa.load_err, 1);

        // Random snapshots
        for (int t = 0; t < 25; t++) begin
            g.delete();
            n = $urandom_range(1, 8);
            for (int j = 0; j < n; j++) begin
                if ($urandom_range(0, 2) == 0) begin
                    g.push_back(ESC);
                    g.push_back(8'($urandom_range(1, 6)));
                    g.push_back(8'($urandom));
                end else begin
                    g.push_back(8'($urandom_range(0, 8'hEC)));
                end
            end
            g.push_back(ESC); g.push_back(8'h00);
            run_load(1'b0);
        end

        // Asynchronous reset in the middle of a run
        for (int k = 0; k < 8; k++) exp_a.push_back({BASE_A + 16'(k), 8'h66});
        for (int k = 0; k < 8; k++) exp_b.push_back({BASE_B + 16'(k), 8'h66});
        ifa.ioctl_index = 8'h01; ifa.ioctl_download = 1'b1;
        tick(); tick();
        ifa.ioctl_wr = 1'b1; ifa.ioctl_dout = ESC;   tick();
        ifa.ioctl_dout = 8'h08;                      tick();
        ifa.ioctl_dout = 8'h66;                      tick();
        ifa.ioctl_wr = 1'b0;
        tick();
        chk("mid_fill_wait", ifa.ioctl_wait, 1);
        ifa.cpu_addr = 16'h1234; ifa.cpu_dout = 8'hC3; ifa.cpu_we = 1'b1;
        reset_n = 1'b0;
        #1;
        chk("arst_wait", ifa.ioctl_wait, 0);
        chk("arst_busy", ifa.load_busy, 0);
        chk("arst_ram_addr", ifa.ram_addr, 16'h1234);
        chk("arst_ram_we", ifa.ram_we, 1);
        ifa.ioctl_download = 1'b0;
        tick();
        reset_n = 1'b1;
        ifa.cpu_we = 1'b0;
        exp_a.delete(); exp_b.delete();
        tick();

        // Recovery load after reset
        g.delete(); g.push_back(8'h5A); g.push_back(ESC); g.push_back(8'h00);
        run_load(1'b0);
        chk("recover_ram2000", sha_a[16'h2000], 8'h5A);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
